// File: rtl/ldpc_wb_slave_if.sv
// Wishbone classic bus bundle between the management SoC and the LDPC slave.
// Signal names keep the SoC-side _i/_o sense (inputs/outputs as seen by the slave).
interface ldpc_wb_slave_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/ldpc_wb_slave.sv
// Wishbone classic slave fronting the LDPC core: message/codeword registers,
// start pulse, busy/done tracking with watchdog, GPIO check word and interrupt.
module ldpc_wb_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          MSG_WORDS = 4,
  parameter int          CW_WORDS  = 6,
  parameter int          TIMEOUT   = 1024
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rstn_i,
  ldpc_wb_slave_if.slave           wbs,
  output logic [32*MSG_WORDS-1:0]  msg_o,
  output logic                     start_o,
  input  logic                     core_done_i,
  input  logic [32*CW_WORDS-1:0]   cw_i,
  output logic [15:0]              chk_o,
  output logic [15:0]              chk_oeb_o,
  output logic                     irq_o
);

  localparam int WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e           state_q, state_d;
  logic [WDW-1:0]   wd_q, wd_d;
  logic             ack_q, ack_d;
  logic [31:0]      rdat_q, rdat_d;
  logic             start_q, start_d;
  logic [15:0]      chk_q, chk_d;
  logic             irq_en_q, irq_en_d;
  logic             done_q, done_d;
  logic             berr_q, berr_d;
  logic             tout_q, tout_d;
  logic             irq_q, irq_d;
  logic [31:0]      msg_q [MSG_WORDS];
  logic [31:0]      msg_d [MSG_WORDS];
  logic [31:0]      cw_q  [CW_WORDS];
  logic [31:0]      cw_d  [CW_WORDS];

  logic             req, wr, rd, start_req;
  logic [5:0]       widx;
  logic [31:0]      rdata;
  logic             unused_adr;

  assign unused_adr = ^wbs.wbs_adr_i[1:0];

  always_comb begin
    state_d  = state_q;
    wd_d     = wd_q;
    chk_d    = chk_q;
    irq_en_d = irq_en_q;
    done_d   = done_q;
    berr_d   = berr_q;
    tout_d   = tout_q;
    msg_d    = msg_q;
    cw_d     = cw_q;
    start_d  = 1'b0;
    rdat_d   = '0;
    start_req = 1'b0;

    // A new request is taken only when no ack is in flight, so acks are never back-to-back.
    req   = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~ack_q &
            (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    wr    = req & wbs.wbs_we_i;
    rd    = req & ~wbs.wbs_we_i;
    widx  = wbs.wbs_adr_i[7:2];
    ack_d = req;

    rdata = '0;
    if (widx == 6'd0) rdata = {chk_q, 14'd0, irq_en_q, 1'b0};
    if (widx == 6'd1) rdata = {28'd0, tout_q, berr_q, done_q, (state_q == S_BUSY)};
    for (int i = 0; i < MSG_WORDS; i++)
      if (widx == 6'(4 + i)) rdata = msg_q[i];
    for (int j = 0; j < CW_WORDS; j++)
      if (widx == 6'(16 + j)) rdata = cw_q[j];
    if (rd) rdat_d = rdata;

    if (wr && widx == 6'd0) begin
      if (wbs.wbs_sel_i[3]) chk_d[15:8] = wbs.wbs_dat_i[31:24];
      if (wbs.wbs_sel_i[2]) chk_d[7:0]  = wbs.wbs_dat_i[23:16];
      if (wbs.wbs_sel_i[0]) begin
        irq_en_d  = wbs.wbs_dat_i[1];
        start_req = wbs.wbs_dat_i[0];
      end
    end

    if (wr && widx == 6'd1 && wbs.wbs_sel_i[0]) begin
      if (wbs.wbs_dat_i[1]) done_d = 1'b0;
      if (wbs.wbs_dat_i[2]) berr_d = 1'b0;
      if (wbs.wbs_dat_i[3]) tout_d = 1'b0;
    end

    // The core reads msg_o while busy, so message writes then are rejected and flagged.
    for (int i = 0; i < MSG_WORDS; i++) begin
      if (wr && widx == 6'(4 + i)) begin
        if (state_q == S_BUSY) begin
          berr_d = 1'b1;
        end else begin
          for (int b = 0; b < 4; b++)
            if (wbs.wbs_sel_i[b]) msg_d[i][8*b +: 8] = wbs.wbs_dat_i[8*b +: 8];
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start_req) begin
          start_d = 1'b1;
          wd_d    = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (start_req) berr_d = 1'b1;
        // Set after the W1C above so a simultaneous clear loses to completion.
        if (core_done_i) begin
          for (int j = 0; j < CW_WORDS; j++) cw_d[j] = cw_i[32*j +: 32];
          done_d  = 1'b1;
          wd_d    = '0;
          state_d = S_IDLE;
        end else if (wd_q == WDW'(TIMEOUT - 1)) begin
          tout_d  = 1'b1;
          wd_d    = '0;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    irq_d = irq_en_d & (done_d | tout_d);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state_q  <= S_IDLE;
      wd_q     <= '0;
      ack_q    <= 1'b0;
      rdat_q   <= '0;
      start_q  <= 1'b0;
      chk_q    <= '0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      berr_q   <= 1'b0;
      tout_q   <= 1'b0;
      irq_q    <= 1'b0;
      for (int i = 0; i < MSG_WORDS; i++) msg_q[i] <= '0;
      for (int j = 0; j < CW_WORDS; j++)  cw_q[j]  <= '0;
    end else begin
      state_q  <= state_d;
      wd_q     <= wd_d;
      ack_q    <= ack_d;
      rdat_q   <= rdat_d;
      start_q  <= start_d;
      chk_q    <= chk_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      berr_q   <= berr_d;
      tout_q   <= tout_d;
      irq_q    <= irq_d;
      msg_q    <= msg_d;
      cw_q     <= cw_d;
    end
  end

  always_comb begin
    msg_o = '0;
    for (int i = 0; i < MSG_WORDS; i++) msg_o[32*i +: 32] = msg_q[i];
  end

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = rdat_q;
  assign start_o       = start_q;
  assign chk_o         = chk_q;
  assign chk_oeb_o     = 16'h0000;
  assign irq_o         = irq_q;

endmodule

// File: tb/tb_ldpc_wb_slave.sv
// Scoreboarded directed bench for ldpc_wb_slave: bus tasks push expected read data,
// a negedge monitor pops on every ack and also tracks start_o pulses.
module tb_ldpc_wb_slave;
  localparam logic [31:0] BASE    = 32'h3000_0000;
  localparam int          MSGW    = 4;
  localparam int          CWW     = 6;
  localparam int          TIMEOUT = 1024;

  typedef struct {
    bit          is_rd;
    logic [31:0] adr;
    logic [31:0] dat;
  } exp_t;

  logic                 clk;
  logic                 rst_n;
  logic [32*MSGW-1:0]   msg_o;
  logic                 start_o;
  logic                 core_done_i;
  logic [32*CWW-1:0]    cw_i;
  logic [15:0]          chk_o;
  logic [15:0]          chk_oeb_o;
  logic                 irq_o;

  ldpc_wb_slave_if wbif();

  ldpc_wb_slave #(
    .BASE_ADDR (BASE),
    .MSG_WORDS (MSGW),
    .CW_WORDS  (CWW),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rstn_i   (rst_n),
    .wbs         (wbif),
    .msg_o       (msg_o),
    .start_o     (start_o),
    .core_done_i (core_done_i),
    .cw_i        (cw_i),
    .chk_o       (chk_o),
    .chk_oeb_o   (chk_oeb_o),
    .irq_o       (irq_o)
  );

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_start = 0;
  int   start_cyc = 0;
  int   cyc_cnt = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Monitor: every ack consumes one scoreboard entry; reads are compared.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wbif.wbs_ack_o) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_ack: got ack=1 expected no ack");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.is_rd) begin
            n_cmp++;
            if (wbif.wbs_dat_o !== e.dat) begin
              n_err++;
              $display("FAIL rdata@%h: got %h expected %h", e.adr, wbif.wbs_dat_o, e.dat);
            end
          end
        end
      end
      if (start_o) begin
        n_start++;
        start_cyc = cyc_cnt;
        n_cmp++;
        if (wbif.wbs_ack_o !== 1'b1) begin
          n_err++;
          $display("FAIL start_with_ack: got ack=%b expected 1", wbif.wbs_ack_o);
        end
      end
    end
  end

  task automatic wb(input bit we, input logic [7:0] off, input logic [31:0] dat,
                    input logic [3:0] sel, input logic [31:0] expv);
    exp_t e;
    e.is_rd = !we;
    e.adr   = BASE | {24'd0, off};
    e.dat   = expv;
    exp_q.push_back(e);
    wbif.wbs_cyc_i = 1'b1;
    wbif.wbs_stb_i = 1'b1;
    wbif.wbs_we_i  = we;
    wbif.wbs_sel_i = sel;
    wbif.wbs_adr_i = BASE | {24'd0, off};
    wbif.wbs_dat_i = dat;
    @(posedge clk); #1;
    chk("ack_rise", {191'd0, wbif.wbs_ack_o}, 192'd1);
    wbif.wbs_cyc_i = 1'b0;
    wbif.wbs_stb_i = 1'b0;
    wbif.wbs_we_i  = 1'b0;
    @(posedge clk); #1;
    chk("ack_fall", {191'd0, wbif.wbs_ack_o}, 192'd0);
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] dat, input logic [3:0] sel);
    wb(1'b1, off, dat, sel, 32'd0);
  endtask

  task automatic rd(input logic [7:0] off, input logic [31:0] expv);
    wb(1'b0, off, 32'd0, 4'hF, expv);
  endtask

  task automatic wb_far(input logic [31:0] adr);
    bit seen;
    seen = 1'b0;
    wbif.wbs_cyc_i = 1'b1;
    wbif.wbs_stb_i = 1'b1;
    wbif.wbs_we_i  = 1'b0;
    wbif.wbs_sel_i = 4'hF;
    wbif.wbs_adr_i = adr;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (wbif.wbs_ack_o) seen = 1'b1;
    end
    chk("out_of_window_noack", {191'd0, seen}, 192'd0);
    wbif.wbs_cyc_i = 1'b0;
    wbif.wbs_stb_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic core_done(input logic [31:0] base);
    for (int j = 0; j < CWW; j++) cw_i[32*j +: 32] = base + 32'(j);
    core_done_i = 1'b1;
    @(posedge clk); #1;
    core_done_i = 1'b0;
  endtask

  logic [32*MSGW-1:0] msg_exp;

  initial begin
    rst_n = 1'b0;
    core_done_i = 1'b0;
    cw_i = '0;
    wbif.wbs_cyc_i = 1'b0;
    wbif.wbs_stb_i = 1'b0;
    wbif.wbs_we_i  = 1'b0;
    wbif.wbs_sel_i = 4'h0;
    wbif.wbs_adr_i = '0;
    wbif.wbs_dat_i = '0;
    #1;
    chk("rst_ack",   {191'd0, wbif.wbs_ack_o}, 192'd0);
    chk("rst_dat",   {160'd0, wbif.wbs_dat_o}, 192'd0);
    chk("rst_start", {191'd0, start_o}, 192'd0);
    chk("rst_msg",   {64'd0, msg_o}, 192'd0);
    chk("rst_chk",   {176'd0, chk_o}, 192'd0);
    chk("rst_irq",   {191'd0, irq_o}, 192'd0);
    chk("chk_oeb",   {176'd0, chk_oeb_o}, 192'd0);
    #21 rst_n = 1'b1;
    @(posedge clk); #1;

    rd(8'h00, 32'h0);
    rd(8'h04, 32'h0);
    rd(8'h10, 32'h0);
    rd(8'h40, 32'h0);

    // First job: message load, start, core completes after 20 cycles.
    for (int i = 0; i < MSGW; i++) begin
      wr(8'(8'h10 + 4*i), 32'hDEAD_0000 + 32'(i), 4'hF);
      msg_exp[32*i +: 32] = 32'hDEAD_0000 + 32'(i);
    end
    chk("msg_o_loaded", {64'd0, msg_o}, {64'd0, msg_exp});
    wr(8'h00, 32'hAB60_0003, 4'hF);
    chk("chk_o_ab60", {176'd0, chk_o}, {176'd0, 16'hAB60});
    rd(8'h04, 32'h1);
    rd(8'h00, 32'hAB60_0002);
    chk("irq_busy_low", {191'd0, irq_o}, 192'd0);
    repeat (14) @(posedge clk);
    #1;
    core_done(32'hC0DE_0000);
    chk("irq_on_done", {191'd0, irq_o}, 192'd1);
    rd(8'h04, 32'h2);
    for (int j = 0; j < CWW; j++) rd(8'(8'h40 + 4*j), 32'hC0DE_0000 + 32'(j));
    wr(8'h04, 32'h2, 4'hF);
    rd(8'h04, 32'h0);
    chk("irq_cleared", {191'd0, irq_o}, 192'd0);
    wr(8'h00, 32'hAB61_0000, 4'b1100);
    chk("chk_o_ab61", {176'd0, chk_o}, {176'd0, 16'hAB61});
    rd(8'h00, 32'hAB61_0002);

    // Second job: illegal accesses while busy, then the watchdog expires.
    wr(8'h00, 32'hAB61_0003, 4'hF);
    wr(8'h00, 32'hAB61_0003, 4'hF);
    wr(8'h14, 32'h1234_5678, 4'hF);
    rd(8'h04, 32'h5);
    rd(8'h14, 32'hDEAD_0001);
    chk("msg_o_unchanged", {64'd0, msg_o}, {64'd0, msg_exp});
    begin
      int k;
      k = 0;
      while (irq_o !== 1'b1 && k < TIMEOUT + 50) begin
        @(negedge clk);
        k++;
      end
    end
    chk("timeout_irq", {191'd0, irq_o}, 192'd1);
    chk("timeout_cycles", 192'(cyc_cnt - start_cyc), 192'(TIMEOUT));
    @(posedge clk); #1;
    rd(8'h04, 32'hC);
    rd(8'h40, 32'hC0DE_0000);
    rd(8'h54, 32'hC0DE_0005);
    core_done(32'hFFFF_0000);
    rd(8'h40, 32'hC0DE_0000);
    rd(8'h04, 32'hC);

    // Byte lanes, unmapped offset inside the window, and an address past it.
    wr(8'h04, 32'hE, 4'h1);
    rd(8'h04, 32'h0);
    wr(8'h18, 32'h1122_3344, 4'b0100);
    rd(8'h18, 32'hDE22_0002);
    wr(8'h00, 32'h0000_0000, 4'h1);
    rd(8'hFC, 32'h0);
    wb_far(BASE + 32'h100);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 192'(exp_q.size()), 192'd0);
    chk("start_pulse_count", 192'(n_start), 192'd2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
